// File: rtl/dc_ipu_mul_unit_serial_mul_ctrl.sv
// ---------------------------------------------------------------------------
// dc_ipu_mul_unit_carry_lookahead_adder
//   4-bit carry-lookahead adder slice. All carries come straight from the
//   generate/propagate terms, so the slice has no ripple path.
//
//   value_a  in  4  addend
//   value_b  in  4  addend
//   c_i      in  1  carry in
//   sum      out 4  value_a + value_b + c_i (low 4 bits)
//   c_o      out 1  carry out
// ---------------------------------------------------------------------------
module dc_ipu_mul_unit_carry_lookahead_adder (
  input  logic [3:0] value_a,
  input  logic [3:0] value_b,
  input  logic       c_i,
  output logic [3:0] sum,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = value_a & value_b;
  assign p = value_a ^ value_b;

  // Each carry is expanded fully from g/p and the carry in.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign sum = p ^ c[3:0];
  assign c_o = c[4];

endmodule

// ---------------------------------------------------------------------------
// dc_ipu_mul_unit_serial_mul_ctrl
//   Serial shift-add unsigned multiplier. A single 4-bit CLA slice is reused
//   for every partial-product addition, one nibble of the upper accumulator
//   per cycle, followed by one shift cycle per multiplier bit. Latency is
//   fixed at WIDTH_B*(WIDTH_A/4+1) cycles from acceptance to out_valid_o.
//
//   clk_i        in  1                clock, rising edge
//   rst_ni       in  1                asynchronous active-low reset
//   in_valid_i   in  1                operand pair valid
//   in_ready_o   out 1                ready to accept (IDLE only)
//   value_a_i    in  WIDTH_A          unsigned multiplicand
//   value_b_i    in  WIDTH_B          unsigned multiplier
//   out_valid_o  out 1                product valid (DONE)
//   out_ready_i  in  1                consumer accepts product
//   product_o    out WIDTH_A+WIDTH_B  registered product
//   busy_o       out 1                high outside IDLE
// ---------------------------------------------------------------------------
module dc_ipu_mul_unit_serial_mul_ctrl #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH_A-1:0]         value_a_i,
  input  logic [WIDTH_B-1:0]         value_b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH_A+WIDTH_B-1:0] product_o,
  output logic                       busy_o
);

  localparam int NIB   = WIDTH_A / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BIT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
  localparam int PW    = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_A-1:0] hi_q, hi_d;
  logic [WIDTH_B-1:0] lo_q, lo_d;
  logic               cy_q, cy_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PW-1:0]      prod_q, prod_d;

  logic [3:0]         hi_nib;
  logic [3:0]         a_nib;
  logic [3:0]         add_b;
  logic [3:0]         add_sum;
  logic               add_co;
  logic [PW:0]        shifted;

  // Pick the current nibble of the accumulator and multiplicand with a
  // constant-index mux, which keeps the select logic explicit.
  always_comb begin
    hi_nib = 4'h0;
    a_nib  = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (nib_q == NIB_W'(k)) begin
        hi_nib = hi_q[4*k +: 4];
        a_nib  = a_q[4*k +: 4];
      end
    end
  end

  // Zero addend when the current multiplier bit is clear; ADD still runs so
  // the latency does not depend on the operand values.
  assign add_b = lo_q[0] ? a_nib : 4'h0;

  dc_ipu_mul_unit_carry_lookahead_adder u_cla (
    .value_a (hi_nib),
    .value_b (add_b),
    .c_i     (cy_q),
    .sum     (add_sum),
    .c_o     (add_co)
  );

  // The carry of the last nibble becomes the new MSB of the accumulator;
  // the accumulator LSB moves into the top of lo_q as a finished product bit.
  assign shifted = {cy_q, hi_q, lo_q} >> 1;

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cy_q    <= 1'b0;
      nib_q   <= '0;
      bit_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cy_q    <= cy_d;
      nib_q   <= nib_d;
      bit_q   <= bit_d;
      prod_q  <= prod_d;
    end
  end

  // Next-state and datapath update. Everything holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cy_d    = cy_q;
    nib_d   = nib_q;
    bit_d   = bit_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = value_a_i;
          lo_d    = value_b_i;
          hi_d    = '0;
          cy_d    = 1'b0;
          nib_d   = '0;
          bit_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        for (int k = 0; k < NIB; k++) begin
          if (nib_q == NIB_W'(k)) begin
            hi_d[4*k +: 4] = add_sum;
          end
        end
        cy_d = add_co;
        if (nib_q == NIB_W'(NIB - 1)) begin
          nib_d   = '0;
          state_d = SHIFT;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end

      SHIFT: begin
        hi_d = shifted[PW-1:WIDTH_B];
        lo_d = shifted[WIDTH_B-1:0];
        cy_d = 1'b0;
        if (bit_q == BIT_W'(WIDTH_B - 1)) begin
          prod_d  = shifted[PW-1:0];
          state_d = DONE;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = ADD;
        end
      end

      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign product_o   = prod_q;

endmodule
